// File: rtl/wb_commit_multi.sv
// ---------------------------------------------------------------------------
// wb_commit_multi
//
// Multi-lane writeback/commit stage. Each cycle it accepts up to LANES
// in-order results (lane 0 is the oldest). It finds the oldest lane that
// takes a trap or redirects the PC, squashes every younger lane, and
// registers the surviving bundle into a valid/ready commit register. After
// it loads a bundle with such an event, the stage sits in FLUSH with
// redirect_valid high until the front end acknowledges with flush_ack.
//
// Configuration macro:
//   WB_VECTORED_MTVEC_EN - when defined, a taken interrupt with
//                          mtvec[1:0]==1 redirects to base + 4*code.
//                          When undefined, every trap goes to mtvec & ~3.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_*                per-lane memory-stage results (flattened, lane 0 in
//                       the low bits); in_ready accepts the whole bundle
//   priv_mode, mstatus, mip, mie, mtvec
//                       CSR state used to qualify interrupts and pick the
//                       trap vector
//   out_*               registered commit bundle, held while out_ready=0
//   trap_*              registered trap information for the bundle
//   redirect_valid/pc   level redirect request, held high in FLUSH
//   flush_ack           front end has taken the redirect
// ---------------------------------------------------------------------------
module wb_commit_multi #(
    parameter int LANES  = 2,
    parameter int XLEN   = 64,
    parameter int CODE_W = 6,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         in_valid,
    output logic                     in_ready,
    input  logic [LANES*XLEN-1:0]    in_pc,
    input  logic [LANES*32-1:0]      in_inst,
    input  logic [LANES*XLEN-1:0]    in_value,
    input  logic [LANES-1:0]         in_wen,
    input  logic [LANES-1:0]         in_trap_valid,
    input  logic [LANES-1:0]         in_is_exc,
    input  logic [LANES-1:0]         in_is_ecall,
    input  logic [LANES*CODE_W-1:0]  in_trap_code,
    input  logic [LANES-1:0]         in_jump,
    input  logic [LANES*XLEN-1:0]    in_jump_pc,
    input  logic [1:0]               priv_mode,
    input  logic [XLEN-1:0]          mstatus,
    input  logic [XLEN-1:0]          mip,
    input  logic [XLEN-1:0]          mie,
    input  logic [XLEN-1:0]          mtvec,
    output logic [LANES-1:0]         out_valid,
    input  logic                     out_ready,
    output logic [LANES*XLEN-1:0]    out_pc,
    output logic [LANES*XLEN-1:0]    out_wdata,
    output logic [LANES*32-1:0]      out_inst,
    output logic [LANES-1:0]         out_wen,
    output logic [LANES*5-1:0]       out_rd,
    output logic                     trap_take,
    output logic [LANE_W-1:0]        trap_lane,
    output logic [CODE_W-1:0]        trap_code,
    output logic                     trap_is_irq,
    output logic [XLEN-1:0]          trap_epc,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    input  logic                     flush_ack
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [LANES-1:0]         out_valid_q, out_valid_d;
    logic [LANES-1:0]         out_wen_q, out_wen_d;
    logic [LANES*XLEN-1:0]    out_pc_q, out_pc_d;
    logic [LANES*XLEN-1:0]    out_wdata_q, out_wdata_d;
    logic [LANES*32-1:0]      out_inst_q, out_inst_d;
    logic [LANES*5-1:0]       out_rd_q, out_rd_d;
    logic                     trap_take_q, trap_take_d;
    logic [LANE_W-1:0]        trap_lane_q, trap_lane_d;
    logic [CODE_W-1:0]        trap_code_q, trap_code_d;
    logic                     trap_is_irq_q, trap_is_irq_d;
    logic [XLEN-1:0]          trap_epc_q, trap_epc_d;
    logic [XLEN-1:0]          redirect_pc_q, redirect_pc_d;

    // Per-lane qualification
    logic                     gen;
    logic [LANES-1:0]         take;
    logic [LANES-1:0]         jump;
    logic [LANES*5-1:0]       lane_rd;

    // Oldest-event selection
    logic                     ev_found;
    logic                     ev_trap;
    logic                     ev_irq;
    logic [LANE_W-1:0]        ev_lane;
    logic [CODE_W-1:0]        ev_code;
    logic [XLEN-1:0]          ev_pc;
    logic [XLEN-1:0]          ev_jump_pc;
    logic [LANES-1:0]         keep;       // lanes at or below the event lane
    logic [LANES-1:0]         trap_mask;  // one-hot trapping lane, if any

    logic [XLEN-1:0]          trap_base;
    logic [XLEN-1:0]          trap_target;
    logic [XLEN-1:0]          redir_target;
    logic                     load;
    logic                     unused_bits;

    assign gen = (priv_mode == 2'd3 && mstatus[3]) || (priv_mode == 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CODE_W-1:0] code;
            assign code = in_trap_code[gi*CODE_W +: CODE_W];
            // Exceptions and ECALL are never masked; interrupts need the
            // global enable plus their own pending and enable bits.
            assign take[gi] = in_valid[gi] && in_trap_valid[gi] &&
                              (in_is_exc[gi] || in_is_ecall[gi] ||
                               (gen && mip[code] && mie[code]));
            assign jump[gi] = in_valid[gi] && in_jump[gi];
            assign lane_rd[gi*5 +: 5] = in_inst[gi*32+7 +: 5];
        end
    endgenerate

    // Walk from the oldest lane; the first trap or jump wins and every
    // younger lane is dropped. A trap beats a jump on the same lane.
    always_comb begin
        ev_found   = 1'b0;
        ev_trap    = 1'b0;
        ev_irq     = 1'b0;
        ev_lane    = '0;
        ev_code    = '0;
        ev_pc      = '0;
        ev_jump_pc = '0;
        keep       = '0;
        trap_mask  = '0;
        for (int i = 0; i < LANES; i++) begin
            keep[i] = !ev_found;
            if (!ev_found && (take[i] || jump[i])) begin
                ev_found     = 1'b1;
                ev_trap      = take[i];
                ev_irq       = take[i] && !(in_is_exc[i] || in_is_ecall[i]);
                ev_lane      = LANE_W'(i);
                ev_code      = in_trap_code[i*CODE_W +: CODE_W];
                ev_pc        = in_pc[i*XLEN +: XLEN];
                ev_jump_pc   = in_jump_pc[i*XLEN +: XLEN];
                trap_mask[i] = take[i];
            end
        end
    end

    assign trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef WB_VECTORED_MTVEC_EN
    // Vectored mode applies to interrupts only; exceptions stay direct.
    assign trap_target = (ev_irq && mtvec[1:0] == 2'b01)
                       ? trap_base + {{(XLEN-CODE_W-2){1'b0}}, ev_code, 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    assign redir_target = ev_trap ? trap_target : ev_jump_pc;

    assign in_ready = !rst && (state_q == S_RUN) && (!(|out_valid_q) || out_ready);
    assign load     = in_ready && (|in_valid);

    always_comb begin
        out_valid_d   = out_valid_q;
        out_wen_d     = out_wen_q;
        out_pc_d      = out_pc_q;
        out_wdata_d   = out_wdata_q;
        out_inst_d    = out_inst_q;
        out_rd_d      = out_rd_q;
        trap_take_d   = trap_take_q;
        trap_lane_d   = trap_lane_q;
        trap_code_d   = trap_code_q;
        trap_is_irq_d = trap_is_irq_q;
        trap_epc_d    = trap_epc_q;
        redirect_pc_d = redirect_pc_q;
        state_d       = state_q;

        if (load) begin
            out_valid_d   = in_valid & keep;
            // The trapping lane commits but must not write its register.
            out_wen_d     = in_wen & in_valid & keep & ~trap_mask;
            out_pc_d      = in_pc;
            out_wdata_d   = in_value;
            out_inst_d    = in_inst;
            out_rd_d      = lane_rd;
            trap_take_d   = ev_trap;
            trap_lane_d   = ev_trap ? ev_lane : '0;
            trap_code_d   = ev_trap ? ev_code : '0;
            trap_is_irq_d = ev_irq;
            trap_epc_d    = ev_trap ? ev_pc : '0;
        end else if (in_ready || out_ready) begin
            // Consumer took the bundle (or it was already empty) and
            // nothing new arrived; this also drains the register in FLUSH.
            out_valid_d   = '0;
            out_wen_d     = '0;
            out_pc_d      = '0;
            out_wdata_d   = '0;
            out_inst_d    = '0;
            out_rd_d      = '0;
            trap_take_d   = 1'b0;
            trap_lane_d   = '0;
            trap_code_d   = '0;
            trap_is_irq_d = 1'b0;
            trap_epc_d    = '0;
        end

        case (state_q)
            S_RUN: begin
                if (load && ev_found) begin
                    state_d       = S_FLUSH;
                    redirect_pc_d = redir_target;
                end
            end
            S_FLUSH: begin
                if (flush_ack) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            out_valid_q   <= '0;
            out_wen_q     <= '0;
            out_pc_q      <= '0;
            out_wdata_q   <= '0;
            out_inst_q    <= '0;
            out_rd_q      <= '0;
            trap_take_q   <= 1'b0;
            trap_lane_q   <= '0;
            trap_code_q   <= '0;
            trap_is_irq_q <= 1'b0;
            trap_epc_q    <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_wen_q     <= out_wen_d;
            out_pc_q      <= out_pc_d;
            out_wdata_q   <= out_wdata_d;
            out_inst_q    <= out_inst_d;
            out_rd_q      <= out_rd_d;
            trap_take_q   <= trap_take_d;
            trap_lane_q   <= trap_lane_d;
            trap_code_q   <= trap_code_d;
            trap_is_irq_q <= trap_is_irq_d;
            trap_epc_q    <= trap_epc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_wen        = out_wen_q;
    assign out_pc         = out_pc_q;
    assign out_wdata      = out_wdata_q;
    assign out_inst       = out_inst_q;
    assign out_rd         = out_rd_q;
    assign trap_take      = trap_take_q;
    assign trap_lane      = trap_lane_q;
    assign trap_code      = trap_code_q;
    assign trap_is_irq    = trap_is_irq_q;
    assign trap_epc       = trap_epc_q;
    assign redirect_valid = (state_q == S_FLUSH);
    assign redirect_pc    = redirect_pc_q;

    // Only MIE of mstatus matters; mtvec mode bits matter only in vectored builds.
    assign unused_bits = ^{mstatus[XLEN-1:4], mstatus[2:0], mtvec[1:0]};

endmodule

// File: tb/tb_wb_commit_multi.sv
`timescale 1ns/1ps
module tb_wb_commit_multi;

    localparam int LANES  = 2;
    localparam int XLEN   = 64;
    localparam int CODE_W = 6;
    localparam int LANE_W = 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [LANES-1:0]         in_valid;
    logic                     in_ready;
    logic [LANES*XLEN-1:0]    in_pc;
    logic [LANES*32-1:0]      in_inst;
    logic [LANES*XLEN-1:0]    in_value;
    logic [LANES-1:0]         in_wen;
    logic [LANES-1:0]         in_trap_valid;
    logic [LANES-1:0]         in_is_exc;
    logic [LANES-1:0]         in_is_ecall;
    logic [LANES*CODE_W-1:0]  in_trap_code;
    logic [LANES-1:0]         in_jump;
    logic [LANES*XLEN-1:0]    in_jump_pc;
    logic [1:0]               priv_mode;
    logic [XLEN-1:0]          mstatus, mip, mie, mtvec;
    logic [LANES-1:0]         out_valid;
    logic                     out_ready;
    logic [LANES*XLEN-1:0]    out_pc, out_wdata;
    logic [LANES*32-1:0]      out_inst;
    logic [LANES-1:0]         out_wen;
    logic [LANES*5-1:0]       out_rd;
    logic                     trap_take;
    logic [LANE_W-1:0]        trap_lane;
    logic [CODE_W-1:0]        trap_code;
    logic                     trap_is_irq;
    logic [XLEN-1:0]          trap_epc;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     flush_ack;

    // Per-lane stimulus, packed onto the flat buses below
    logic [XLEN-1:0]   s_pc   [LANES];
    logic [XLEN-1:0]   s_val  [LANES];
    logic [XLEN-1:0]   s_jpc  [LANES];
    logic [31:0]       s_inst [LANES];
    logic [CODE_W-1:0] s_code [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_pack
            assign in_pc[gi*XLEN +: XLEN]          = s_pc[gi];
            assign in_value[gi*XLEN +: XLEN]       = s_val[gi];
            assign in_jump_pc[gi*XLEN +: XLEN]     = s_jpc[gi];
            assign in_inst[gi*32 +: 32]            = s_inst[gi];
            assign in_trap_code[gi*CODE_W +: CODE_W] = s_code[gi];
        end
    endgenerate

    wb_commit_multi #(.LANES(LANES), .XLEN(XLEN), .CODE_W(CODE_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_value(in_value), .in_wen(in_wen),
        .in_trap_valid(in_trap_valid), .in_is_exc(in_is_exc), .in_is_ecall(in_is_ecall),
        .in_trap_code(in_trap_code), .in_jump(in_jump), .in_jump_pc(in_jump_pc),
        .priv_mode(priv_mode), .mstatus(mstatus), .mip(mip), .mie(mie), .mtvec(mtvec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_wdata(out_wdata), .out_inst(out_inst),
        .out_wen(out_wen), .out_rd(out_rd),
        .trap_take(trap_take), .trap_lane(trap_lane), .trap_code(trap_code),
        .trap_is_irq(trap_is_irq), .trap_epc(trap_epc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_ack(flush_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    function automatic logic [XLEN-1:0] o_pc(int i);
        return out_pc[i*XLEN +: XLEN];
    endfunction
    function automatic logic [XLEN-1:0] o_data(int i);
        return out_wdata[i*XLEN +: XLEN];
    endfunction
    function automatic logic [4:0] o_rd(int i);
        return out_rd[i*5 +: 5];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = '0; in_wen = '0; in_trap_valid = '0; in_is_exc = '0;
        in_is_ecall = '0; in_jump = '0;
        for (int i = 0; i < LANES; i++) begin
            s_pc[i] = '0; s_val[i] = '0; s_jpc[i] = '0; s_inst[i] = '0; s_code[i] = '0;
        end
        priv_mode = 2'd3; mstatus = '0; mip = '0; mie = '0; mtvec = '0;
        flush_ack = 1'b0; out_ready = 1'b1;
    endtask

    task automatic set_lane(int i, logic [XLEN-1:0] pc, logic [4:0] rd, logic [XLEN-1:0] val);
        s_pc[i]   = pc;
        s_inst[i] = 32'h0000_0013 | ({27'd0, rd} << 7);
        s_val[i]  = val;
        s_jpc[i]  = pc + 4;
    endtask

    task automatic do_ack();
        in_valid  = '0;
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        #2;
        total++;
        if ({out_valid, out_wen, trap_take, trap_is_irq, redirect_valid, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_flags got valid=%b wen=%b take=%b irq=%b redir=%b in_ready=%b want all 0",
                     out_valid, out_wen, trap_take, trap_is_irq, redirect_valid, in_ready);
        end
        total++;
        if ({out_pc, out_wdata, redirect_pc, trap_epc} !== '0) begin
            bad++;
            $display("FAIL reset_data got pc=%h redir_pc=%h epc=%h want 0", out_pc, redirect_pc, trap_epc);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got in_ready=%b redir=%b want 1 0", in_ready, redirect_valid);
        end
        $display("txn reset done");
    endtask

    // ---------------------------------------------------------------
    task automatic test_plain();
        clear_inputs();
        set_lane(0, 64'h1000, 5'd5,  64'hDEAD_0000_0000_0001);
        set_lane(1, 64'h1004, 5'd10, 64'hBEEF_0000_0000_0002);
        in_valid = 2'b11; in_wen = 2'b11;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL plain_in_ready got %b want 1", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 2'b11 || out_wen !== 2'b11) begin
            bad++; $display("FAIL plain_valid got valid=%b wen=%b want 11 11", out_valid, out_wen);
        end
        total++;
        if (o_pc(0) !== 64'h1000 || o_pc(1) !== 64'h1004 ||
            o_data(0) !== 64'hDEAD_0000_0000_0001 || o_data(1) !== 64'hBEEF_0000_0000_0002) begin
            bad++; $display("FAIL plain_data got pc0=%h pc1=%h d0=%h d1=%h", o_pc(0), o_pc(1), o_data(0), o_data(1));
        end
        total++;
        if (o_rd(0) !== 5'd5 || o_rd(1) !== 5'd10) begin
            bad++; $display("FAIL plain_rd got %0d %0d want 5 10", o_rd(0), o_rd(1));
        end
        total++;
        if (redirect_valid !== 1'b0 || trap_take !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL plain_noredir got redir=%b take=%b in_ready=%b want 0 0 1",
                            redirect_valid, trap_take, in_ready);
        end
        in_valid = '0;
        tick();
        total++;
        if (out_valid !== 2'b00) begin
            bad++; $display("FAIL plain_clear got valid=%b want 00", out_valid);
        end
        $display("txn plain bundle retired");
    endtask

    // ---------------------------------------------------------------
    task automatic test_ecall();
        clear_inputs();
        priv_mode = 2'd0; mtvec = 64'h8000_0100;
        set_lane(0, 64'h2000, 5'd1, 64'h11);
        set_lane(1, 64'h2004, 5'd2, 64'h22);
        in_valid = 2'b11; in_wen = 2'b11;
        in_trap_valid = 2'b01; in_is_ecall = 2'b01; s_code[0] = 6'd8;
        tick();
        in_valid = '0;
        #1;
        total++;
        if (out_valid !== 2'b01 || out_wen !== 2'b00) begin
            bad++; $display("FAIL ecall_valid got valid=%b wen=%b want 01 00", out_valid, out_wen);
        end
        total++;
        if (trap_take !== 1'b1 || trap_lane !== 1'b0 || trap_is_irq !== 1'b0 ||
            trap_code !== 6'd8 || trap_epc !== 64'h2000) begin
            bad++; $display("FAIL ecall_trap got take=%b lane=%0d irq=%b code=%0d epc=%h",
                            trap_take, trap_lane, trap_is_irq, trap_code, trap_epc);
        end
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100 || in_ready !== 1'b0) begin
            bad++; $display("FAIL ecall_redirect got redir=%b pc=%h in_ready=%b want 1 80000100 0",
                            redirect_valid, redirect_pc, in_ready);
        end
        tick();
        total++;
        if (out_valid !== 2'b00 || redirect_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL ecall_drain got valid=%b redir=%b in_ready=%b want 00 1 0",
                            out_valid, redirect_valid, in_ready);
        end
        flush_ack = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL ecall_ack_same got in_ready=%b want 0", in_ready);
        end
        tick();
        flush_ack = 1'b0;
        total++;
        if (in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL ecall_ack_next got in_ready=%b redir=%b want 1 0", in_ready, redirect_valid);
        end
        $display("txn ecall trap and flush");
    endtask

    // ---------------------------------------------------------------
    task automatic test_irq();
        clear_inputs();
        priv_mode = 2'd3; mstatus = '0; mtvec = 64'h8000_0000;
        mip = 64'h80; mie = 64'h80;
        set_lane(0, 64'h3000, 5'd3, 64'h33);
        set_lane(1, 64'h3004, 5'd4, 64'h44);
        in_valid = 2'b11; in_wen = 2'b11;
        in_trap_valid = 2'b10; s_code[1] = 6'd7;
        tick();
        total++;
        if (out_valid !== 2'b11 || out_wen !== 2'b11 || trap_take !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL irq_masked got valid=%b wen=%b take=%b redir=%b want 11 11 0 0",
                            out_valid, out_wen, trap_take, redirect_valid);
        end
        mstatus = 64'h8;
        tick();
        in_valid = '0;
        total++;
        if (out_valid !== 2'b11 || out_wen !== 2'b01) begin
            bad++; $display("FAIL irq_valid got valid=%b wen=%b want 11 01", out_valid, out_wen);
        end
        total++;
        if (trap_take !== 1'b1 || trap_lane !== 1'b1 || trap_is_irq !== 1'b1 ||
            trap_code !== 6'd7 || trap_epc !== 64'h3004) begin
            bad++; $display("FAIL irq_trap got take=%b lane=%0d irq=%b code=%0d epc=%h",
                            trap_take, trap_lane, trap_is_irq, trap_code, trap_epc);
        end
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0000) begin
            bad++; $display("FAIL irq_redirect got redir=%b pc=%h want 1 80000000", redirect_valid, redirect_pc);
        end
        do_ack();
        $display("txn irq masked then taken");
    endtask

    // ---------------------------------------------------------------
    task automatic test_jump();
        clear_inputs();
        priv_mode = 2'd0; mtvec = 64'h8000_0100;
        set_lane(0, 64'h4000, 5'd6, 64'h66);
        set_lane(1, 64'h4004, 5'd7, 64'h77);
        s_jpc[0] = 64'h8000_2000;
        in_valid = 2'b11; in_wen = 2'b11;
        in_jump = 2'b01; in_trap_valid = 2'b10; in_is_ecall = 2'b10;
        tick();
        in_valid = '0;
        total++;
        if (out_valid !== 2'b01 || out_wen !== 2'b01 || trap_take !== 1'b0) begin
            bad++; $display("FAIL jump_valid got valid=%b wen=%b take=%b want 01 01 0", out_valid, out_wen, trap_take);
        end
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_2000) begin
            bad++; $display("FAIL jump_redirect got redir=%b pc=%h want 1 80002000", redirect_valid, redirect_pc);
        end
        do_ack();
        $display("txn jump squashes younger trap");
    endtask

    // ---------------------------------------------------------------
    task automatic test_back_to_back();
        clear_inputs();
        out_ready = 1'b0;
        set_lane(0, 64'h5000, 5'd8, 64'h88);
        set_lane(1, 64'h5004, 5'd9, 64'h99);
        in_valid = 2'b11; in_wen = 2'b10;
        tick();
        set_lane(0, 64'h6000, 5'd11, 64'hAA);
        set_lane(1, 64'h6004, 5'd12, 64'hBB);
        in_wen = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 2'b11 || out_wen !== 2'b10 ||
                o_pc(0) !== 64'h5000 || o_pc(1) !== 64'h5004 || o_data(1) !== 64'h99) begin
                bad++; $display("FAIL hold_%0d got in_ready=%b valid=%b wen=%b pc0=%h pc1=%h",
                                c, in_ready, out_valid, out_wen, o_pc(0), o_pc(1));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = '0;
        total++;
        if (out_valid !== 2'b11 || out_wen !== 2'b01 || o_pc(0) !== 64'h6000 || o_rd(1) !== 5'd12) begin
            bad++; $display("FAIL release_next got valid=%b wen=%b pc0=%h rd1=%0d want 11 01 6000 12",
                            out_valid, out_wen, o_pc(0), o_rd(1));
        end
        tick();
        total++;
        if (out_valid !== 2'b00) begin
            bad++; $display("FAIL release_clear got valid=%b want 00", out_valid);
        end
        $display("txn backpressure hold and release");
    endtask

    // ---------------------------------------------------------------
    task automatic test_vectored_and_reset();
        logic [XLEN-1:0] exp_pc;
        clear_inputs();
        priv_mode = 2'd3; mstatus = 64'h8; mip = 64'h80; mie = 64'h80;
        mtvec = 64'h8000_0001;
        set_lane(0, 64'h7000, 5'd13, 64'hCC);
        in_valid = 2'b01; in_wen = 2'b01;
        in_trap_valid = 2'b01; s_code[0] = 6'd7;
`ifdef WB_VECTORED_MTVEC_EN
        exp_pc = 64'h8000_001C;
`else
        exp_pc = 64'h8000_0000;
`endif
        tick();
        in_valid = '0;
        total++;
        if (trap_take !== 1'b1 || trap_is_irq !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
            bad++; $display("FAIL vector_pc got take=%b irq=%b redir=%b pc=%h want 1 1 1 %h",
                            trap_take, trap_is_irq, redirect_valid, redirect_pc, exp_pc);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_wen, trap_take, trap_is_irq, redirect_valid, in_ready} !== '0 ||
            redirect_pc !== '0 || trap_epc !== '0 || out_pc !== '0) begin
            bad++; $display("FAIL flush_reset got valid=%b take=%b redir=%b pc=%h in_ready=%b want all 0",
                            out_valid, trap_take, redirect_valid, redirect_pc, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || out_valid !== 2'b00) begin
            bad++; $display("FAIL flush_reset_run got in_ready=%b redir=%b valid=%b want 1 0 00",
                            in_ready, redirect_valid, out_valid);
        end
        $display("txn vectored trap then reset in flush");
    endtask

    // ---------------------------------------------------------------
    // Reference model state for the randomized run
    logic             m_flush;
    logic [LANES-1:0] m_valid, m_wen;
    logic             m_take, m_irq;
    logic [LANE_W-1:0] m_lane;
    logic [CODE_W-1:0] m_code;
    logic [XLEN-1:0]  m_epc, m_redir;
    logic [XLEN-1:0]  m_pc [LANES];
    logic [XLEN-1:0]  m_data [LANES];
    logic [4:0]       m_rd [LANES];

    task automatic test_random();
        logic             exp_ready, g, qual, ktrap, load;
        int               k;
        logic [LANES-1:0] nv, nw;
        logic [XLEN-1:0]  target;
        logic [31:0]      r;
        m_flush = 1'b0; m_valid = '0; m_wen = '0; m_take = 1'b0; m_irq = 1'b0;
        m_lane = '0; m_code = '0; m_epc = '0; m_redir = '0;
        for (int i = 0; i < LANES; i++) begin
            m_pc[i] = '0; m_data[i] = '0; m_rd[i] = '0;
        end
        for (int n = 0; n < 120; n++) begin
            in_valid = 2'($urandom_range(0, 3));
            in_wen = 2'($urandom_range(0, 3));
            in_is_exc = 2'($urandom_range(0, 3));
            in_is_ecall = 2'($urandom_range(0, 3));
            for (int i = 0; i < LANES; i++) begin
                in_trap_valid[i] = ($urandom_range(0, 3) == 0);
                in_jump[i]       = ($urandom_range(0, 4) == 0);
                if (in_trap_valid[i] && $urandom_range(0, 1) == 1) begin
                    in_is_exc[i] = 1'b0; in_is_ecall[i] = 1'b0;
                end
                s_pc[i]   = {$urandom(), $urandom()};
                s_val[i]  = {$urandom(), $urandom()};
                s_jpc[i]  = {$urandom(), $urandom()};
                s_inst[i] = $urandom();
                s_code[i] = CODE_W'($urandom_range(0, 63));
            end
            priv_mode = 2'($urandom_range(0, 3));
            mstatus   = {$urandom(), $urandom()};
            mip       = {$urandom(), $urandom()};
            mie       = {$urandom(), $urandom()};
            r         = $urandom();
            mtvec     = {32'h0, 16'h8000, r[15:0]};
            out_ready = ($urandom_range(0, 3) != 0);
            flush_ack = ($urandom_range(0, 2) == 0);
            #1;
            exp_ready = !m_flush && (m_valid == '0 || out_ready);
            total++;
            if (in_ready !== exp_ready) begin
                bad++; $display("FAIL rnd_in_ready n=%0d got %b want %b", n, in_ready, exp_ready);
            end

            // Oldest lane with a qualified trap or a jump
            g = (priv_mode == 2'd3 && mstatus[3]) || priv_mode == 2'd0;
            k = -1; ktrap = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (k < 0 && in_valid[i]) begin
                    qual = in_trap_valid[i] &&
                           (in_is_exc[i] || in_is_ecall[i] || (g && mip[s_code[i]] && mie[s_code[i]]));
                    if (qual || in_jump[i]) begin
                        k = i; ktrap = qual;
                    end
                end
            end
            nv = '0; nw = '0;
            for (int i = 0; i < LANES; i++) begin
                if (k < 0 || i <= k) begin
                    nv[i] = in_valid[i];
                    nw[i] = in_valid[i] && in_wen[i] && !(ktrap && i == k);
                end
            end
            target = '0;
            if (k >= 0) begin
                if (ktrap) begin
                    target = mtvec & ~64'd3;
`ifdef WB_VECTORED_MTVEC_EN
                    if (!in_is_exc[k] && !in_is_ecall[k] && mtvec[1:0] == 2'b01)
                        target = target + 64'(s_code[k]) * 4;
`endif
                end else begin
                    target = s_jpc[k];
                end
            end

            load = exp_ready && (in_valid != '0);
            if (load) begin
                m_valid = nv; m_wen = nw;
                m_take  = ktrap;
                m_lane  = ktrap ? LANE_W'(k) : '0;
                m_code  = ktrap ? s_code[k] : '0;
                m_irq   = ktrap && !in_is_exc[k] && !in_is_ecall[k];
                m_epc   = ktrap ? s_pc[k] : '0;
                for (int i = 0; i < LANES; i++) begin
                    m_pc[i] = s_pc[i]; m_data[i] = s_val[i]; m_rd[i] = s_inst[i][11:7];
                end
            end else if (exp_ready || out_ready) begin
                m_valid = '0; m_wen = '0; m_take = 1'b0;
            end
            if (m_flush) begin
                if (flush_ack) m_flush = 1'b0;
            end else if (load && k >= 0) begin
                m_flush = 1'b1; m_redir = target;
            end

            tick();
            $display("txn rnd %0d load=%b valid=%b wen=%b take=%b lane=%0d flush=%b",
                     n, load, m_valid, m_wen, m_take, m_lane, m_flush);
            total++;
            if (out_valid !== m_valid || out_wen !== m_wen || trap_take !== m_take) begin
                bad++; $display("FAIL rnd_bundle n=%0d got valid=%b wen=%b take=%b want %b %b %b",
                                n, out_valid, out_wen, trap_take, m_valid, m_wen, m_take);
            end
            if (m_take) begin
                total++;
                if (trap_lane !== m_lane || trap_code !== m_code || trap_is_irq !== m_irq || trap_epc !== m_epc) begin
                    bad++; $display("FAIL rnd_trap n=%0d got lane=%0d code=%0d irq=%b epc=%h want %0d %0d %b %h",
                                    n, trap_lane, trap_code, trap_is_irq, trap_epc, m_lane, m_code, m_irq, m_epc);
                end
            end
            total++;
            if (redirect_valid !== m_flush) begin
                bad++; $display("FAIL rnd_redir_valid n=%0d got %b want %b", n, redirect_valid, m_flush);
            end
            if (m_flush) begin
                total++;
                if (redirect_pc !== m_redir) begin
                    bad++; $display("FAIL rnd_redir_pc n=%0d got %h want %h", n, redirect_pc, m_redir);
                end
            end
            for (int i = 0; i < LANES; i++) begin
                if (m_valid[i]) begin
                    total++;
                    if (o_pc(i) !== m_pc[i] || o_data(i) !== m_data[i] || o_rd(i) !== m_rd[i]) begin
                        bad++; $display("FAIL rnd_lane%0d n=%0d got pc=%h d=%h rd=%0d want %h %h %0d",
                                        i, n, o_pc(i), o_data(i), o_rd(i), m_pc[i], m_data[i], m_rd[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_plain();
        test_ecall();
        test_irq();
        test_jump();
        test_back_to_back();
        test_vectored_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
